// File: rtl/usart_rx.sv
// rtl/usart_rx.sv - 8N1 asynchronous serial receiver with one-byte holding register
// Bit timing comes from the run-time clocks_per_bit divisor, latched at each start edge.
module usart_rx (
    input  logic        serial_clock,
    input  logic        reset_n,
    input  logic [11:0] clocks_per_bit,
    input  logic        rx_pin,
    input  logic        read_in,
    output logic [7:0]  data_out,
    output logic        data_valid,
    output logic        framing_error,
    output logic        overrun_error,
    output logic        busy
);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_IDLE
    } state_t;

    state_t      state, state_nx;
    logic        sync_meta, rx_sync;
    logic [11:0] period, period_nx;
    logic [11:0] count, count_nx;
    logic [2:0]  bit_idx, bit_idx_nx;
    logic [7:0]  shift, shift_nx;
    logic [11:0] p_eff;
    logic        commit;
    logic        set_fe;

    // Divisors below 2 would leave no room for a mid-bit sample point.
    assign p_eff = (clocks_per_bit < 12'd2) ? 12'd2 : clocks_per_bit;
    assign busy  = (state != IDLE);

    always_ff @(posedge serial_clock or negedge reset_n) begin
        if (!reset_n) begin
            sync_meta <= 1'b1;
            rx_sync   <= 1'b1;
        end else begin
            sync_meta <= rx_pin;
            rx_sync   <= sync_meta;
        end
    end

    always_ff @(posedge serial_clock or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            period  <= 12'd2;
            count   <= 12'd0;
            bit_idx <= 3'd0;
            shift   <= 8'h00;
        end else begin
            state   <= state_nx;
            period  <= period_nx;
            count   <= count_nx;
            bit_idx <= bit_idx_nx;
            shift   <= shift_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        period_nx  = period;
        count_nx   = count;
        bit_idx_nx = bit_idx;
        shift_nx   = shift;
        commit     = 1'b0;
        set_fe     = 1'b0;
        case (state)
            IDLE: begin
                if (!rx_sync) begin
                    period_nx = p_eff;
                    count_nx  = (p_eff >> 1) - 12'd1;
                    state_nx  = START;
                end
            end
            START: begin
                if (count == 12'd0) begin
                    if (rx_sync) begin
                        state_nx = IDLE;
                    end else begin
                        state_nx   = DATA;
                        count_nx   = period - 12'd1;
                        bit_idx_nx = 3'd0;
                    end
                end else begin
                    count_nx = count - 12'd1;
                end
            end
            DATA: begin
                if (count == 12'd0) begin
                    shift_nx = {rx_sync, shift[7:1]};
                    count_nx = period - 12'd1;
                    if (bit_idx == 3'd7) begin
                        state_nx = STOP;
                    end else begin
                        bit_idx_nx = bit_idx + 3'd1;
                    end
                end else begin
                    count_nx = count - 12'd1;
                end
            end
            STOP: begin
                if (count == 12'd0) begin
                    if (rx_sync) begin
                        commit   = 1'b1;
                        state_nx = IDLE;
                    end else begin
                        set_fe   = 1'b1;
                        state_nx = WAIT_IDLE;
                    end
                end else begin
                    count_nx = count - 12'd1;
                end
            end
            WAIT_IDLE: begin
                // A held-low line (break) reports only one framing error.
                if (rx_sync) begin
                    state_nx = IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge serial_clock or negedge reset_n) begin
        if (!reset_n) begin
            data_out      <= 8'h00;
            data_valid    <= 1'b0;
            framing_error <= 1'b0;
            overrun_error <= 1'b0;
        end else begin
            if (commit) begin
                data_out   <= shift;
                data_valid <= 1'b1;
            end else if (read_in) begin
                data_valid <= 1'b0;
            end

            if (commit && data_valid && !read_in) begin
                overrun_error <= 1'b1;
            end else if (read_in) begin
                overrun_error <= 1'b0;
            end

            if (set_fe) begin
                framing_error <= 1'b1;
            end else if (read_in) begin
                framing_error <= 1'b0;
            end
        end
    end

endmodule

// File: doc/usart_rx.md
Name: usart_rx

Overview:
- Asynchronous serial receiver: the receive counterpart of the team's usart transmitter, using the same 8N1 frame and the same run-time `clocks_per_bit` divisor.
- Frame format: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1), idle high.
- Synchronises `rx_pin`, finds the start edge, samples each bit at mid-bit and places the byte in a one-entry holding register with a valid/read handshake.
- Sits beside the transmitter in the serial peripheral and feeds the CPU-side bus interface.

Parameters:
- None. Bit timing comes from the `clocks_per_bit` port.

Ports:
- serial_clock  input  1  sole clock; every register is clocked on its rising edge
- reset_n  input  1  asynchronous active-low reset
- clocks_per_bit  input  12  serial_clock cycles per bit; sampled only in IDLE
- rx_pin  input  1  serial line, asynchronous to serial_clock
- read_in  input  1  one-cycle pulse; consumer has taken data_out
- data_out  output  8  last received byte
- data_valid  output  1  holding register full
- framing_error  output  1  sticky: a stop bit was sampled low
- overrun_error  output  1  sticky: a byte completed while data_valid=1 and no read_in
- busy  output  1  a frame is in progress (state is not IDLE)

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE; data_out=8'h00; data_valid=0; framing_error=0; overrun_error=0; busy=0.
  - Both synchroniser flops and rx_sync reset to 1.
  - Reset mid-frame abandons the frame with no output change beyond the reset values.
- Synchroniser: two flops on `rx_pin`, giving `rx_sync`. All references below use `rx_sync`.
- Effective period P = max(clocks_per_bit, 2); H = floor(P/2). P is latched on leaving IDLE and held for the whole frame.
- t0 = the first cycle in IDLE where rx_sync=0.
- State machine:
  - IDLE: busy=0. On rx_sync=0, latch P and go to START; busy=1 from t0+1.
  - START: at t0+H, sample rx_sync. If 1, the start was false: return to IDLE with no flags changed. If 0, go to DATA.
  - DATA: bit n (n=0..7) is sampled at t0+H+(n+1)·P and shifted in LSB first.
  - STOP: the stop bit is sampled at Ts = t0+H+9·P.
    - Stop=1: the byte commits at Ts+1 and state returns to IDLE at Ts+1.
    - Stop=0: framing_error=1 at Ts+1, the byte is discarded, and state goes to WAIT_IDLE.
  - WAIT_IDLE: stay until rx_sync=1, then go to IDLE. A line held low (break) produces exactly one framing error.
- Commit rules, applied at Ts+1:
  - data_valid=0: data_out=byte, data_valid=1.
  - data_valid=1, no read_in in the same cycle: data_out is overwritten with the new byte, data_valid stays 1, overrun_error=1.
  - read_in in the same cycle as the commit: the new byte loads, data_valid stays 1, no overrun.
- read_in with no commit in the same cycle:
  - Clears data_valid, framing_error and overrun_error on the next edge.
  - data_out holds its value.
  - read_in while data_valid=0 still clears the error flags.
- Counter: 12-bit down-counter, reloaded with H-1 on entry to START and with P-1 after every sample. It never wraps.
- clocks_per_bit changes take effect only at the next IDLE→START transition.
- No back-to-back gap is needed: a falling edge observed at Ts+1 or later starts the next frame.

Test Plan:
- Nominal byte, clocks_per_bit=16, frame for 8'hA5 driven at 16 cycles/bit -> data_valid=1 with data_out=8'hA5 at Ts+1 = t0+153; framing_error=0, overrun_error=0; busy falls with the return to IDLE.
- Handshake and overrun:
  - Bytes 8'h3C then 8'h7E with no read_in -> data_out=8'h7E, overrun_error=1.
  - A read_in pulse then gives data_valid=0, overrun_error=0 and data_out=8'h7E held.
  - Repeat with read_in asserted exactly at the second commit cycle -> overrun_error stays 0.
- Framing error: frame 8'h55 with the stop bit driven 0, line held low for 40 bit times -> framing_error=1 once, data_valid stays 0; the next good 8'h12 frame is received normally.
- Glitch rejection, clocks_per_bit=16: low pulse of 5 cycles on rx_pin -> state back to IDLE, no flags, data_valid=0; a proper frame follows correctly.
- Divisor edge cases:
  - clocks_per_bit=0 and =1 each behave as P=2: frame 8'hF0 at 2 cycles/bit is received.
  - clocks_per_bit=12'hFFF: frame 8'h81 received.
  - Changing clocks_per_bit mid-frame does not disturb the current byte.
- Async reset: assert reset_n low during data bit 4 of a frame -> all outputs reach their reset values immediately; after release, the next full frame 8'hC3 is received correctly.
